grid_mem_arbiter: RTL and testbench

Single-port arbiter for the 32x32x8-bit temperature grid RAM of the heat-equation solver. It shares one synchronous RAM port between three requesters: the VGA heat-map scanout reader, the host access path (ui_in modes 01 write and 10 read), and the 5-point stencil sweep engine (mode 00 run). It grants one access per cycle, registers the RAM command, and routes read data back to the owning requester. An anti-starvation counter guarantees forward progress for the solver.

---
 rtl/grid_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_grid_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_mem_arbiter.sv
// rtl/grid_mem_arbiter.sv - single-port grid RAM arbiter (VGA > host > solver, solver anti-starvation)
// Optional GRID_ARB_STATS_EN adds the o_stat_conflicts counter.
module grid_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vga_req,
  input  logic              i_host_req,
  input  logic              i_sol_req,
  input  logic              i_host_we,
  input  logic              i_sol_we,
  input  logic [ADDR_W-1:0] i_vga_addr,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [ADDR_W-1:0] i_sol_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  input  logic [DATA_W-1:0] i_sol_wdata,
  output logic              o_vga_gnt,
  output logic              o_host_gnt,
  output logic              o_sol_gnt,
  output logic              o_vga_rvalid,
  output logic              o_host_rvalid,
  output logic              o_sol_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
`ifdef GRID_ARB_STATS_EN
  output logic [15:0]       o_stat_conflicts,
`endif
  output logic [7:0]        o_starve_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_HOST = 2'd2,
    OWN_SOL  = 2'd3
  } owner_t;

  logic [7:0]        r_starve_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  owner_t            r_tag1_owner;
  logic              r_tag1_rd;
  owner_t            r_tag2_owner;
  logic              r_tag2_rd;

  logic              w_promote;
  logic              w_vga_gnt;
  logic              w_host_gnt;
  logic              w_sol_gnt;
  owner_t            w_owner;
  logic              w_any;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_promote = (r_starve_cnt >= 8'(STARVE_LIMIT));

  // VGA always wins; a starved solver jumps ahead of the host only.
  always_comb begin
    w_vga_gnt  = i_vga_req;
    w_sol_gnt  = i_sol_req & ~i_vga_req & (~i_host_req | w_promote);
    w_host_gnt = i_host_req & ~i_vga_req & ~w_sol_gnt;
  end

  always_comb begin
    w_owner = OWN_NONE;
    w_we    = 1'b0;
    w_addr  = r_mem_addr;
    w_wdata = r_mem_wdata;
    if (w_vga_gnt) begin
      w_owner = OWN_VGA;
      w_addr  = i_vga_addr;
    end else if (w_host_gnt) begin
      w_owner = OWN_HOST;
      w_we    = i_host_we;
      w_addr  = i_host_addr;
      w_wdata = i_host_wdata;
    end else if (w_sol_gnt) begin
      w_owner = OWN_SOL;
      w_we    = i_sol_we;
      w_addr  = i_sol_addr;
      w_wdata = i_sol_wdata;
    end
  end

  assign w_any = (w_owner != OWN_NONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_tag1_owner <= OWN_NONE;
      r_tag1_rd    <= 1'b0;
      r_tag2_owner <= OWN_NONE;
      r_tag2_rd    <= 1'b0;
      r_starve_cnt <= 8'd0;
    end else begin
      r_mem_en <= w_any;
      if (w_any) begin
        r_mem_we    <= w_we;
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
      end
      // Tag stage 2 lines up with the cycle the RAM presents read data.
      r_tag1_owner <= w_owner;
      r_tag1_rd    <= w_any & ~w_we;
      r_tag2_owner <= r_tag1_owner;
      r_tag2_rd    <= r_tag1_rd;
      if (i_sol_req & ~w_sol_gnt) begin
        if (r_starve_cnt != 8'hFF) begin
          r_starve_cnt <= r_starve_cnt + 8'd1;
        end
      end else begin
        r_starve_cnt <= 8'd0;
      end
    end
  end

`ifdef GRID_ARB_STATS_EN
  logic [15:0] r_stat_conflicts;
  logic        w_conflict;

  assign w_conflict = (i_vga_req & i_host_req) | (i_vga_req & i_sol_req) | (i_host_req & i_sol_req);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat_conflicts <= 16'd0;
    end else if (w_conflict && (r_stat_conflicts != 16'hFFFF)) begin
      r_stat_conflicts <= r_stat_conflicts + 16'd1;
    end
  end

  assign o_stat_conflicts = r_stat_conflicts;
`endif

  assign o_vga_gnt     = w_vga_gnt;
  assign o_host_gnt    = w_host_gnt;
  assign o_sol_gnt     = w_sol_gnt;
  assign o_vga_rvalid  = r_tag2_rd & (r_tag2_owner == OWN_VGA);
  assign o_host_rvalid = r_tag2_rd & (r_tag2_owner == OWN_HOST);
  assign o_sol_rvalid  = r_tag2_rd & (r_tag2_owner == OWN_SOL);
  assign o_rdata       = i_mem_rdata;
  assign o_mem_en      = r_mem_en;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_starve_cnt  = r_starve_cnt;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// tb/tb_grid_mem_arbiter.sv - testbench for grid_mem_arbiter with read-first RAM model and reference scoreboard
module tb_grid_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       vga_req, host_req, sol_req, host_we, sol_we;
  logic [9:0] vga_addr, host_addr, sol_addr;
  logic [7:0] host_wdata, sol_wdata;
  logic       vga_gnt, host_gnt, sol_gnt;
  logic       vga_rv, host_rv, sol_rv;
  logic [7:0] rdata;
  logic       mem_en, mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] starve_cnt;
`ifdef GRID_ARB_STATS_EN
  logic [15:0] stat_conflicts;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] ram [1024];
  logic [7:0] ref_mem [1024];
  logic       ram_load = 1'b0;

  always #5 clk = ~clk;

  grid_mem_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_vga_req(vga_req), .i_host_req(host_req), .i_sol_req(sol_req),
    .i_host_we(host_we), .i_sol_we(sol_we),
    .i_vga_addr(vga_addr), .i_host_addr(host_addr), .i_sol_addr(sol_addr),
    .i_host_wdata(host_wdata), .i_sol_wdata(sol_wdata),
    .o_vga_gnt(vga_gnt), .o_host_gnt(host_gnt), .o_sol_gnt(sol_gnt),
    .o_vga_rvalid(vga_rv), .o_host_rvalid(host_rv), .o_sol_rvalid(sol_rv),
    .o_rdata(rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
`ifdef GRID_ARB_STATS_EN
    .o_stat_conflicts(stat_conflicts),
`endif
    .o_starve_cnt(starve_cnt)
  );

  // Read-first synchronous RAM standing in for the grid memory.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) ram[i] <= ref_mem[i];
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic idle_inputs();
    vga_req = 0; host_req = 0; sol_req = 0; host_we = 0; sol_we = 0;
    vga_addr = 0; host_addr = 0; sol_addr = 0; host_wdata = 0; sol_wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    ram_load = 1;
    @(posedge clk); #1 ram_load = 0;
    @(negedge clk);
    checks++; if ({vga_gnt, host_gnt, sol_gnt} !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", {vga_gnt, host_gnt, sol_gnt}); end
    checks++; if ({vga_rv, host_rv, sol_rv} !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", {vga_rv, host_rv, sol_rv}); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin failures++; $display("FAIL reset_mem_en_we got=%b exp=00", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 10'd0 || mem_wdata !== 8'd0) begin failures++; $display("FAIL reset_mem_addr_wdata got=%0d/%0d exp=0/0", mem_addr, mem_wdata); end
    checks++; if (starve_cnt !== 8'd0) begin failures++; $display("FAIL reset_starve got=%0d exp=0", starve_cnt); end
    @(posedge clk); #1 rst = 0;
    // Two reads in flight, then reset again.
    host_req = 1; host_we = 0; host_addr = 10'd5;
    @(posedge clk); #1 host_req = 0; vga_req = 1; vga_addr = 10'd6;
    @(posedge clk); #1 vga_req = 0; rst = 1;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 20'd0) begin failures++; $display("FAIL midreset_mem got=%b/%b/%0d/%0d exp=0", mem_en, mem_we, mem_addr, mem_wdata); end
    checks++; if ({vga_rv, host_rv, sol_rv} !== 3'b000) begin failures++; $display("FAIL midreset_rvalid got=%b exp=000", {vga_rv, host_rv, sol_rv}); end
    @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({vga_rv, host_rv, sol_rv} !== 3'b000) begin failures++; $display("FAIL postreset_rvalid cyc=%0d got=%b exp=000", k, {vga_rv, host_rv, sol_rv}); end
    end
  endtask

  task automatic test_host_write_read();
    @(posedge clk); #1 host_req = 1; host_we = 1; host_addr = 10'd528; host_wdata = 8'hFF;
    ref_mem[528] = 8'hFF;
    @(negedge clk);
    checks++; if ({vga_gnt, host_gnt, sol_gnt} !== 3'b010) begin failures++; $display("FAIL hwr_write_gnt got=%b exp=010", {vga_gnt, host_gnt, sol_gnt}); end
    @(posedge clk); #1 host_we = 0;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd528, 8'hFF}) begin failures++; $display("FAIL hwr_write_cmd got=%b/%b/%0d/%h exp=1/1/528/ff", mem_en, mem_we, mem_addr, mem_wdata); end
    checks++; if (host_gnt !== 1'b1) begin failures++; $display("FAIL hwr_read_gnt got=%b exp=1", host_gnt); end
    @(posedge clk); #1 host_req = 0;
    @(negedge clk);
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd528}) begin failures++; $display("FAIL hwr_read_cmd got=%b/%b/%0d exp=1/0/528", mem_en, mem_we, mem_addr); end
    checks++; if (host_rv !== 1'b0) begin failures++; $display("FAIL hwr_write_no_rvalid got=%b exp=0", host_rv); end
    @(negedge clk);
    checks++; if (host_rv !== 1'b1 || rdata !== 8'hFF) begin failures++; $display("FAIL hwr_read_data got=%b/%h exp=1/ff", host_rv, rdata); end
  endtask

  task automatic test_vga_priority();
    logic [2:0] exp_gnt, exp_rv;
    int exp_cnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 host_req = 1; host_we = 1; host_addr = 10'(i); host_wdata = 8'(8'h11 * (i + 1));
      ref_mem[i] = 8'(8'h11 * (i + 1));
    end
    @(posedge clk); #1 host_req = 0; host_we = 0;
    vga_addr = 10'd0; host_addr = 10'd1; sol_addr = 10'd2; sol_we = 0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1 vga_req = (j == 0); host_req = (j <= 1); sol_req = (j <= 2);
      @(negedge clk);
      exp_gnt = (j == 0) ? 3'b100 : (j == 1) ? 3'b010 : (j == 2) ? 3'b001 : 3'b000;
      exp_rv  = (j == 2) ? 3'b100 : (j == 3) ? 3'b010 : (j == 4) ? 3'b001 : 3'b000;
      exp_cnt = (j <= 2) ? j : 0;
      checks++; if ({vga_gnt, host_gnt, sol_gnt} !== exp_gnt) begin failures++; $display("FAIL prio_gnt cyc=%0d got=%b exp=%b", j, {vga_gnt, host_gnt, sol_gnt}, exp_gnt); end
      checks++; if ({vga_rv, host_rv, sol_rv} !== exp_rv) begin failures++; $display("FAIL prio_rvalid cyc=%0d got=%b exp=%b", j, {vga_rv, host_rv, sol_rv}, exp_rv); end
      checks++; if (starve_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL prio_starve cyc=%0d got=%0d exp=%0d", j, starve_cnt, exp_cnt); end
      if (j >= 2) begin
        checks++; if (rdata !== ref_mem[j - 2]) begin failures++; $display("FAIL prio_rdata cyc=%0d got=%h exp=%h", j, rdata, ref_mem[j - 2]); end
      end
    end
    @(posedge clk); #1 idle_inputs();
  endtask

  task automatic test_starvation();
    logic [2:0] exp_gnt;
    int exp_cnt;
    repeat (2) @(posedge clk);
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1 host_req = 1; host_addr = 10'd10; sol_req = 1; sol_addr = 10'd20;
      @(negedge clk);
      exp_gnt = (k == 15) ? 3'b001 : 3'b010;
      exp_cnt = (k == 16) ? 0 : k;
      checks++; if ({vga_gnt, host_gnt, sol_gnt} !== exp_gnt) begin failures++; $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", k, {vga_gnt, host_gnt, sol_gnt}, exp_gnt); end
      checks++; if (starve_cnt !== 8'(exp_cnt)) begin failures++; $display("FAIL starve_cnt cyc=%0d got=%0d exp=%0d", k, starve_cnt, exp_cnt); end
    end
    @(posedge clk); #1 idle_inputs();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int rcount = 0;
    for (int i = 0; i < 1026; i++) begin
      @(posedge clk); #1 sol_req = (i < 1024); sol_we = 0; sol_addr = 10'(i);
      @(negedge clk);
      if (i < 1024) begin
        checks++; if (sol_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=1", i, sol_gnt); end
      end
      if (i >= 2) begin
        checks++; if (sol_rv !== 1'b1 || rdata !== ref_mem[i - 2]) begin failures++; $display("FAIL b2b_read cyc=%0d got=%b/%h exp=1/%h", i, sol_rv, rdata, ref_mem[i - 2]); end
        if (sol_rv === 1'b1) rcount++;
      end
    end
    checks++; if (rcount != 1024) begin failures++; $display("FAIL b2b_count got=%0d exp=1024", rcount); end
    @(posedge clk); #1 idle_inputs();
    repeat (3) @(posedge clk);
  endtask

  typedef struct {
    int         due;
    logic [2:0] own;
    logic [7:0] data;
  } rd_t;

  task automatic test_random();
    rd_t        q[$];
    rd_t        e;
    int         m_cnt = 0;
    logic [2:0] g = 3'b000;
    logic [2:0] eg, erv;
    logic       p_en = 0, p_we = 0, we;
    logic [9:0] p_addr = 0, a;
    logic [7:0] p_wdata = 0, wd, edata;
    for (int c = 0; c < 403; c++) begin
      @(posedge clk); #1;
      if (c >= 400) begin
        idle_inputs();
      end else begin
        if (!vga_req || g[2]) begin vga_req = ($urandom_range(0, 3) == 0); vga_addr = 10'($urandom_range(0, 15)); end
        else if ($urandom_range(0, 15) == 0) vga_req = 0;
        if (!host_req || g[1]) begin
          host_req = ($urandom_range(0, 3) != 0); host_we = 1'($urandom_range(0, 1));
          host_addr = 10'($urandom_range(0, 15)); host_wdata = 8'($urandom_range(0, 255));
        end else if ($urandom_range(0, 15) == 0) host_req = 0;
        if (!sol_req || g[0]) begin
          sol_req = ($urandom_range(0, 1) != 0); sol_we = 1'($urandom_range(0, 1));
          sol_addr = 10'($urandom_range(0, 15)); sol_wdata = 8'($urandom_range(0, 255));
        end else if ($urandom_range(0, 31) == 0) sol_req = 0;
      end
      @(negedge clk);
      if (vga_req) eg = 3'b100;
      else if (sol_req && (m_cnt >= 15 || !host_req)) eg = 3'b001;
      else if (host_req) eg = 3'b010;
      else eg = 3'b000;
      checks++; if ({vga_gnt, host_gnt, sol_gnt} !== eg) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, {vga_gnt, host_gnt, sol_gnt}, eg); end
      checks++; if (starve_cnt !== 8'(m_cnt)) begin failures++; $display("FAIL rnd_starve cyc=%0d got=%0d exp=%0d", c, starve_cnt, m_cnt); end
      checks++; if (mem_en !== p_en) begin failures++; $display("FAIL rnd_mem_en cyc=%0d got=%b exp=%b", c, mem_en, p_en); end
      if (p_en) begin
        checks++; if (mem_we !== p_we || mem_addr !== p_addr) begin failures++; $display("FAIL rnd_mem_cmd cyc=%0d got=%b/%0d exp=%b/%0d", c, mem_we, mem_addr, p_we, p_addr); end
        if (p_we) begin
          checks++; if (mem_wdata !== p_wdata) begin failures++; $display("FAIL rnd_mem_wdata cyc=%0d got=%h exp=%h", c, mem_wdata, p_wdata); end
        end
      end
      erv = 3'b000; edata = 8'h00;
      if (q.size() > 0 && q[0].due == c) begin e = q.pop_front(); erv = e.own; edata = e.data; end
      checks++; if ({vga_rv, host_rv, sol_rv} !== erv) begin failures++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, {vga_rv, host_rv, sol_rv}, erv); end
      if (erv != 3'b000) begin
        checks++; if (rdata !== edata) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rdata, edata); end
      end
      g = eg;
      p_en = (eg != 3'b000);
      if (p_en) begin
        we = eg[2] ? 1'b0 : eg[1] ? host_we : sol_we;
        a  = eg[2] ? vga_addr : eg[1] ? host_addr : sol_addr;
        wd = eg[1] ? host_wdata : sol_wdata;
        p_we = we; p_addr = a;
        if (we) begin p_wdata = wd; ref_mem[a] = wd; end
        else q.push_back('{c + 2, eg, ref_mem[a]});
      end
      m_cnt = (sol_req && eg != 3'b001) ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0;
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_pending got=%0d exp=0", q.size()); end
  endtask

`ifdef GRID_ARB_STATS_EN
  task automatic test_stats();
    idle_inputs();
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    checks++; if (stat_conflicts !== 16'd0) begin failures++; $display("FAIL stats_reset got=%0d exp=0", stat_conflicts); end
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 vga_req = 1; host_req = 1; vga_addr = 10'(i); host_addr = 10'(i + 100); host_we = 0;
    end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    checks++; if (stat_conflicts !== 16'd10) begin failures++; $display("FAIL stats_count got=%0d exp=10", stat_conflicts); end
  endtask
`endif

  initial begin
    test_reset();
    test_host_write_read();
    test_vga_priority();
    test_starvation();
    test_back_to_back();
    test_random();
`ifdef GRID_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
